traffic_light_multi: RTL
========================

Name: traffic_light_multi

Overview:
- Parametrised successor to the single-approach red/yellow/green controller.
- Sequences NUM_DIRS approaches round-robin through GREEN -> YELLOW -> ALL_RED, with programmable phase durations.
- Adds a latched pedestrian request that truncates the current green, and a synchronous flashing-yellow override.
- Sits between intersection timing logic and the lamp drivers.

Parameters:
- NUM_DIRS, 2, number of approaches; must be >= 2.
- CNT_W, 8, phase counter width; every *_CYC value must be <= 2^CNT_W-1.
- GREEN_CYC, 20, nominal green length in clk cycles.
- YELLOW_CYC, 4, yellow length in cycles.
- ALLRED_CYC, 2, all-red clearance length in cycles.
- MIN_GREEN_CYC, 5, minimum green before a pedestrian request may end it; 1 <= MIN_GREEN_CYC <= GREEN_CYC.
- FLASH_CYC, 10, half-period of the flashing yellow, in cycles.
- WALK_CYC, 8, walk indication length; used only with TLC_WALK_EN.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- ped_req  in  1  pedestrian request; level or pulse, sampled every cycle
- flash  in  1  flashing-yellow override, sampled synchronously
- red  out  NUM_DIRS  red lamp per approach
- yellow  out  NUM_DIRS  yellow lamp per approach
- green  out  NUM_DIRS  green lamp per approach
- active_dir  out  DIR_W=max(1,$clog2(NUM_DIRS))  approach currently owning the right-of-way
- ped_ack  out  1  one-cycle pulse when a pending request is served
- walk  out  NUM_DIRS  walk indication; constant 0 unless TLC_WALK_EN

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - Values on reset: state=ALL_RED, cnt=0, active_dir=0, ped_pend=0, blink=0.
  - Outputs on reset: red=all 1, yellow=0, green=0, ped_ack=0, walk=0.
  - Reset asserted mid-phase: the same values are applied at the next edge.
- Outputs are a Moore decode of registered state; lamps change on the same edge as the state.
- cnt clears on every state change and otherwise increments by 1.
- States:
  - ALL_RED: all red=1. When cnt==ALLRED_CYC-1 -> GREEN. active_dir is unchanged.
  - GREEN: green[active_dir]=1; every other approach red=1.
    - Exit to YELLOW when cnt==GREEN_CYC-1.
    - Also exit to YELLOW when ped_pend==1 and cnt>=MIN_GREEN_CYC-1.
  - YELLOW: yellow[active_dir]=1; every other approach red=1. When cnt==YELLOW_CYC-1 -> ALL_RED.
    - active_dir advances on this transition: +1, wrapping from NUM_DIRS-1 to 0.
  - FLASH: red=0, green=0, yellow=all {NUM_DIRS{blink}}.
    - blink is 1 on the first FLASH cycle and toggles every FLASH_CYC cycles.
- At most one approach is non-red at any time. Exactly one lamp is lit per approach outside FLASH.
- Full rotation per approach is GREEN_CYC+YELLOW_CYC+ALLRED_CYC cycles (26 with defaults).
- First green after reset release: the edge sampling reset=0 starts ALL_RED cnt=0. green[0] rises ALLRED_CYC cycles later.
- Pedestrian request handling:
  - ped_req=1 sets ped_pend.
  - ped_pend clears on every entry to YELLOW, whatever the cause.
  - ped_ack=1 for the first YELLOW cycle only when ped_pend was set at that transition.
  - ped_req asserted on the edge that enters YELLOW is absorbed by that ack and not re-latched.
  - Request arriving in YELLOW or ALL_RED stays pending. It truncates the next green at MIN_GREEN_CYC.
  - Request arriving in GREEN after cnt already passed MIN_GREEN_CYC-1 ends green at the next edge.
- flash: top priority below reset.
  - Entering FLASH: when flash=1 from any state, the next state is FLASH. cnt=0 and ped_pend=0 on entry.
  - Leaving FLASH: when flash deasserts, the next state is ALL_RED with cnt=0. active_dir keeps its value.
  - ped_req is ignored while in FLASH.

Optional Feature:
- TLC_WALK_EN defined: walk[active_dir]=1 during GREEN for cnt < min(WALK_CYC, green length actually served).
  - walk drops on the GREEN->YELLOW transition, including pedestrian truncation.
  - walk=0 in every other state.
- TLC_WALK_EN undefined: walk tied to 0. No walk logic is synthesised. Port list is unchanged.

Test Plan:
- Reset release, defaults, no requests:
  - red=2'b11 for 2 cycles, then green=2'b01 for 20, yellow=2'b01 for 4, red=2'b11 for 2.
  - Then green=2'b10 with active_dir=1. Period is 52 cycles.
- ped_req pulse at GREEN cnt=1: green lasts exactly 5 cycles. ped_ack pulses in the first YELLOW cycle. The next approach gets the full 20.
- ped_req pulse during YELLOW: the following approach's green lasts 5 cycles, then ped_ack=1.
- flash=1 mid-GREEN for 25 cycles:
  - Next cycle red=0, green=0, yellow=2'b11 for 10 cycles, then 2'b00 for 10, then 2'b11.
  - After release: ALL_RED for 2 cycles, then green on the same active_dir.
- reset=1 for one cycle mid-YELLOW of approach 1: next cycle red=2'b11, active_dir=0, ped_ack=0. The sequence restarts as in the first scenario.
- NUM_DIRS=3, TLC_WALK_EN defined: active_dir runs 0,1,2,0. walk[d]=1 for the first 8 cycles of each green.
  - An assertion checks that no two approaches are ever non-red simultaneously.

Source files
------------

// File: rtl/traffic_light_multi.sv
// traffic_light_multi: round-robin multi-approach traffic light controller
//
// Sequences NUM_DIRS approaches through GREEN -> YELLOW -> ALL_RED with
// programmable phase lengths, a latched pedestrian request that may cut a
// green short after MIN_GREEN_CYC cycles, and a flashing-yellow override.
// Optional walk indication is built only when TLC_WALK_EN is defined.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   ped_req    in   pedestrian request (level or pulse)
//   flash      in   flashing-yellow override
//   red        out  [NUM_DIRS] red lamp per approach
//   yellow     out  [NUM_DIRS] yellow lamp per approach
//   green      out  [NUM_DIRS] green lamp per approach
//   active_dir out  [DIR_W] approach owning the right-of-way
//   ped_ack    out  one-cycle pulse when a pending request is served
//   walk       out  [NUM_DIRS] walk indication (0 unless TLC_WALK_EN)
module traffic_light_multi #(
    parameter int NUM_DIRS      = 2,
    parameter int CNT_W         = 8,
    parameter int GREEN_CYC     = 20,
    parameter int YELLOW_CYC    = 4,
    parameter int ALLRED_CYC    = 2,
    parameter int MIN_GREEN_CYC = 5,
    parameter int FLASH_CYC     = 10,
    parameter int WALK_CYC      = 8,
    localparam int DIR_W        = (NUM_DIRS > 2) ? $clog2(NUM_DIRS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ped_req,
    input  logic                flash,
    output logic [NUM_DIRS-1:0] red,
    output logic [NUM_DIRS-1:0] yellow,
    output logic [NUM_DIRS-1:0] green,
    output logic [DIR_W-1:0]    active_dir,
    output logic                ped_ack,
    output logic [NUM_DIRS-1:0] walk
);
    typedef enum logic [1:0] {S_ALL_RED, S_GREEN, S_YELLOW, S_FLASH} state_e;

    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_CYC - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIR_W-1:0]   dir_q, dir_d;
    logic               pend_q, pend_d;
    logic               blink_q, blink_d;
    logic               ack_q, ack_d;
    logic [NUM_DIRS-1:0] dir_oh;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_ALL_RED;
            cnt_q   <= '0;
            dir_q   <= '0;
            pend_q  <= 1'b0;
            blink_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            blink_q <= blink_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        blink_d = blink_q;
        ack_d   = 1'b0;
        if (flash) begin
            state_d = S_FLASH;
            if (state_q != S_FLASH)
                blink_d = 1'b1;
            else if (cnt_q == FLASH_LAST)
                blink_d = ~blink_q;
        end else begin
            case (state_q)
                S_ALL_RED: if (cnt_q == ALLRED_LAST) state_d = S_GREEN;
                S_GREEN: if (cnt_q == GREEN_LAST || (pend_q && cnt_q >= MIN_LAST)) begin
                    state_d = S_YELLOW;
                    ack_d   = pend_q;
                end
                S_YELLOW: if (cnt_q == YELLOW_LAST) begin
                    state_d = S_ALL_RED;
                    dir_d   = (dir_q == DIR_W'(NUM_DIRS - 1)) ? '0 : dir_q + 1'b1;
                end
                default: state_d = S_ALL_RED;
            endcase
        end
        // In FLASH the counter measures one blink half-period and restarts.
        cnt_d  = (state_d != state_q || (state_q == S_FLASH && cnt_q == FLASH_LAST)) ? '0 : cnt_q + 1'b1;
        // Requests are dropped on any yellow entry and never held across FLASH.
        pend_d = (state_d == S_FLASH || state_q == S_FLASH || (state_d == S_YELLOW && state_q != S_YELLOW))
                 ? 1'b0 : (pend_q | ped_req);
    end

    assign dir_oh     = NUM_DIRS'(1) << dir_q;
    assign red        = (state_q == S_ALL_RED) ? '1 : (state_q == S_FLASH) ? '0 : ~dir_oh;
    assign green      = (state_q == S_GREEN) ? dir_oh : '0;
    assign yellow     = (state_q == S_YELLOW) ? dir_oh : (state_q == S_FLASH) ? {NUM_DIRS{blink_q}} : '0;
    assign active_dir = dir_q;
    assign ped_ack    = ack_q;

`ifdef TLC_WALK_EN
    // cnt < served green length holds throughout GREEN, so only WALK_CYC bounds it here.
    assign walk = (state_q == S_GREEN && 32'(cnt_q) < WALK_CYC) ? dir_oh : '0;
`else
    assign walk = NUM_DIRS'(WALK_CYC) & '0;
`endif
endmodule
